// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - CHIP-8 fetch/issue controller with next-PC logic and return stack
module fetch_sequencer #(
    parameter logic [11:0] RESET_PC    = 12'h200,
    parameter int          STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_valid,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        pc_skip,
    input  logic        pc_jump,
    input  logic        pc_call,
    input  logic        pc_ret,
    input  logic [11:0] pc_target,
    output logic [11:0] pc,
    output logic [3:0]  sp,
    output logic        fault
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ_HI  = 3'd1;
    localparam logic [2:0] WAIT_HI = 3'd2;
    localparam logic [2:0] REQ_LO  = 3'd3;
    localparam logic [2:0] WAIT_LO = 3'd4;
    localparam logic [2:0] ISSUE   = 3'd5;
    localparam logic [2:0] EXEC    = 3'd6;
    localparam logic [2:0] FAULT   = 3'd7;

    localparam logic [3:0] SP_FULL = 4'(STACK_DEPTH - 1);

    logic [2:0]  state;
    logic [11:0] stack [STACK_DEPTH];
    logic [11:0] next_pc;
    logic [3:0]  next_sp;
    logic        push;
    logic        ex_fault;

    // Flow-control resolution; ret > call > jump > skip > normal.
    always_comb begin
        next_pc  = pc + 12'd2;
        next_sp  = sp;
        push     = 1'b0;
        ex_fault = 1'b0;
        if (pc_ret) begin
            if (sp == 4'd0) begin
                ex_fault = 1'b1;
                next_pc  = pc;
            end else begin
                next_sp = sp - 4'd1;
                next_pc = stack[sp - 4'd1];
            end
        end else if (pc_call) begin
            if (sp == SP_FULL) begin
                ex_fault = 1'b1;
                next_pc  = pc;
            end else begin
                push    = 1'b1;
                next_sp = sp + 4'd1;
                next_pc = pc_target;
            end
        end else if (pc_jump) begin
            next_pc = pc_target;
        end else if (pc_skip) begin
            next_pc = pc + 12'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            sp       <= 4'd0;
            instr    <= 16'h0000;
            mem_addr <= 12'h000;
            fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= REQ_HI;
                        mem_addr <= pc;
                    end
                end
                REQ_HI:  state <= WAIT_HI;
                WAIT_HI: begin
                    if (mem_valid) begin
                        instr[15:8] <= mem_rdata;
                        mem_addr    <= pc + 12'd1;
                        state       <= REQ_LO;
                    end
                end
                REQ_LO:  state <= WAIT_LO;
                WAIT_LO: begin
                    if (mem_valid) begin
                        instr[7:0] <= mem_rdata;
                        state      <= ISSUE;
                    end
                end
                ISSUE:   state <= EXEC;
                EXEC: begin
                    if (exec_done) begin
                        if (ex_fault) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc <= next_pc;
                            sp <= next_sp;
                            if (run) begin
                                state    <= REQ_HI;
                                mem_addr <= next_pc;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= FAULT;
            endcase
        end
    end

    // Stack storage is deliberately left out of reset; sp alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && state == EXEC && exec_done && push) begin
            stack[sp] <= pc + 12'd2;
        end
    end

    assign mem_rd      = (state == REQ_HI) || (state == REQ_LO);
    assign instr_valid = (state == ISSUE);

endmodule
